// File: rtl/cb_input_conditioner.sv
// Conditions raw joystick/OSD bits into the active-low Canyon Bomber cabinet inputs:
// per-button debounce, one fixed-width coin pulse per press, and blanking during download/reset.
module cb_input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int COIN_PULSE_CYCLES = 600000,
    parameter int COIN_GAP_CYCLES   = 600000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    input  logic        test_sw,
    input  logic        ioctl_download,
    output logic        Coin1_n,
    output logic        Start1_n,
    output logic        Start2_n,
    output logic        Fire1_n,
    output logic        Fire2_n,
    output logic        Test_n,
    output logic        coin_busy,
    output logic [1:0]  coin_state
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int COIN_MAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ? COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    localparam int CW       = $clog2(COIN_MAX + 1);
    localparam int NBITS    = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } coin_state_t;

    // Download blanking shares the reset path so the inputs re-qualify from scratch.
    logic blank;
    assign blank = reset || ioctl_download;

    // Bit order: 0 fire1, 1 fire2, 2 start1, 3 start2, 4 coin.
    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] db_level;
    logic [DB_W-1:0]  db_cnt [NBITS];

    assign raw = {joy0[7] | joy1[7], joy0[6], joy0[5], joy1[4], joy0[4]};

    logic unused_joy;
    assign unused_joy = ^{joy0[15:8], joy0[3:0], joy1[15:8], joy1[6:5], joy1[3:0]};

    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < NBITS; i++) begin
            if (blank) begin
                db_level[i] <= 1'b0;
                db_cnt[i]   <= '0;
            end else if (raw[i] == db_level[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level[i] <= ~db_level[i];
                db_cnt[i]   <= '0;
            end else begin
                db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
        end
    end

    coin_state_t   state_q, state_d;
    logic [CW-1:0] coin_cnt_q, coin_cnt_d;
    logic          dc;

    assign dc = db_level[4];

    always_ff @(posedge clk_sys) begin
        if (blank) begin
            state_q    <= IDLE;
            coin_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

    // Counter loads phase length minus one and counts down, so it cannot wrap.
    always_comb begin
        state_d    = state_q;
        coin_cnt_d = coin_cnt_q;
        case (state_q)
            IDLE: begin
                if (dc) begin
                    state_d    = PULSE;
                    coin_cnt_d = CW'(COIN_PULSE_CYCLES - 1);
                end
            end
            PULSE: begin
                if (coin_cnt_q == '0) begin
                    state_d    = GAP;
                    coin_cnt_d = CW'(COIN_GAP_CYCLES - 1);
                end else begin
                    coin_cnt_d = coin_cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (coin_cnt_q == '0) begin
                    state_d = dc ? WAIT_REL : IDLE;
                end else begin
                    coin_cnt_d = coin_cnt_q - CW'(1);
                end
            end
            WAIT_REL: begin
                if (!dc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                coin_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (blank) begin
            Coin1_n  <= 1'b1;
            Start1_n <= 1'b1;
            Start2_n <= 1'b1;
            Fire1_n  <= 1'b1;
            Fire2_n  <= 1'b1;
            Test_n   <= 1'b1;
        end else begin
            Coin1_n  <= (state_q != PULSE);
            Start1_n <= ~db_level[2];
            Start2_n <= ~db_level[3];
            Fire1_n  <= ~db_level[0];
            Fire2_n  <= ~db_level[1];
            Test_n   <= ~test_sw;
        end
    end

    assign coin_busy  = (state_q != IDLE);
    assign coin_state = state_q;

endmodule
